// File: rtl/msrv32_pkg.sv
// Shared encodings for the MSRV32 machine-mode trap sequencer.
package msrv32_pkg;

    typedef enum logic [1:0] {
        ST_RESET       = 2'b00,
        ST_OPERATING   = 2'b01,
        ST_TRAP_TAKEN  = 2'b10,
        ST_TRAP_RETURN = 2'b11
    } mc_state_e;

    // PC mux select codes
    localparam logic [1:0] PC_BOOT = 2'b00;
    localparam logic [1:0] PC_EPC  = 2'b01;
    localparam logic [1:0] PC_TRAP = 2'b10;
    localparam logic [1:0] PC_NEXT = 2'b11;

    // mcause exception codes (interrupt bit carried separately)
    localparam logic [3:0] CAUSE_INSTR_MISALIGNED = 4'd0;
    localparam logic [3:0] CAUSE_ILLEGAL_INSTR    = 4'd2;
    localparam logic [3:0] CAUSE_BREAKPOINT       = 4'd3;
    localparam logic [3:0] CAUSE_LOAD_MISALIGNED  = 4'd4;
    localparam logic [3:0] CAUSE_STORE_MISALIGNED = 4'd6;
    localparam logic [3:0] CAUSE_ECALL_M          = 4'd11;

    // mcause interrupt codes
    localparam logic [3:0] CAUSE_M_SW_INT  = 4'd3;
    localparam logic [3:0] CAUSE_M_TMR_INT = 4'd7;
    localparam logic [3:0] CAUSE_M_EXT_INT = 4'd11;

    // SYSTEM instruction decode constants
    localparam logic [4:0] OPC_SYSTEM   = 5'b11100;
    localparam logic [2:0] FUNCT3_PRIV  = 3'b000;
    localparam logic [6:0] FUNCT7_MRET  = 7'b0011000;
    localparam logic [4:0] RS2_MRET     = 5'b00010;
    localparam logic [4:0] RS2_EBREAK   = 5'b00001;
    localparam logic [4:0] RS2_ECALL    = 5'b00000;

endpackage

// File: rtl/msrv32_trap_prioritizer.sv
// Combinational trap resolver: decodes ECALL/EBREAK/MRET and picks the
// highest-priority exception or enabled interrupt with its mcause code.
module msrv32_trap_prioritizer
    import msrv32_pkg::*;
(
    input  logic       illegal_instr_i,
    input  logic       misaligned_load_i,
    input  logic       misaligned_store_i,
    input  logic       misaligned_instr_i,
    input  logic [4:0] opcode_6_to_2_i,
    input  logic [2:0] funct3_i,
    input  logic [6:0] funct7_i,
    input  logic [4:0] rs1_addr_i,
    input  logic [4:0] rs2_addr_i,
    input  logic [4:0] rd_addr_i,
    input  logic       mie_i,
    input  logic       meie_i,
    input  logic       mtie_i,
    input  logic       msie_i,
    input  logic       meip_i,
    input  logic       mtip_i,
    input  logic       msip_i,
    output logic       trap_o,
    output logic       mret_o,
    output logic [3:0] cause_o,
    output logic       i_or_e_o
);

    logic is_priv;
    logic is_ecall;
    logic is_ebreak;

    assign is_priv   = (opcode_6_to_2_i == OPC_SYSTEM) && (funct3_i == FUNCT3_PRIV) &&
                       (rs1_addr_i == '0) && (rd_addr_i == '0);
    assign is_ecall  = is_priv && (funct7_i == '0) && (rs2_addr_i == RS2_ECALL);
    assign is_ebreak = is_priv && (funct7_i == '0) && (rs2_addr_i == RS2_EBREAK);
    assign mret_o    = is_priv && (funct7_i == FUNCT7_MRET) && (rs2_addr_i == RS2_MRET);

    // Fixed priority: synchronous exceptions first, then enabled interrupts
    always_comb begin
        trap_o   = 1'b0;
        cause_o  = '0;
        i_or_e_o = 1'b0;
        if (misaligned_instr_i) begin
            trap_o  = 1'b1;
            cause_o = CAUSE_INSTR_MISALIGNED;
        end else if (illegal_instr_i) begin
            trap_o  = 1'b1;
            cause_o = CAUSE_ILLEGAL_INSTR;
        end else if (is_ebreak) begin
            trap_o  = 1'b1;
            cause_o = CAUSE_BREAKPOINT;
        end else if (misaligned_load_i) begin
            trap_o  = 1'b1;
            cause_o = CAUSE_LOAD_MISALIGNED;
        end else if (misaligned_store_i) begin
            trap_o  = 1'b1;
            cause_o = CAUSE_STORE_MISALIGNED;
        end else if (is_ecall) begin
            trap_o  = 1'b1;
            cause_o = CAUSE_ECALL_M;
        end else if (mie_i && meie_i && meip_i) begin
            trap_o   = 1'b1;
            cause_o  = CAUSE_M_EXT_INT;
            i_or_e_o = 1'b1;
        end else if (mie_i && msie_i && msip_i) begin
            trap_o   = 1'b1;
            cause_o  = CAUSE_M_SW_INT;
            i_or_e_o = 1'b1;
        end else if (mie_i && mtie_i && mtip_i) begin
            trap_o   = 1'b1;
            cause_o  = CAUSE_M_TMR_INT;
            i_or_e_o = 1'b1;
        end
    end

endmodule

// File: rtl/msrv32_machine_control.sv
// MSRV32 trap/privilege sequencer: boot hold, trap entry and MRET return,
// driving the PC mux select, pipeline flush and CSR update strobes.
module msrv32_machine_control
    import msrv32_pkg::*;
#(
    parameter int unsigned BOOT_HOLD_CYCLES = 1
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       illegal_instr_in,
    input  logic       misaligned_load_in,
    input  logic       misaligned_store_in,
    input  logic       misaligned_instr_in,
    input  logic [4:0] opcode_6_to_2_in,
    input  logic [2:0] funct3_in,
    input  logic [6:0] funct7_in,
    input  logic [4:0] rs1_addr_in,
    input  logic [4:0] rs2_addr_in,
    input  logic [4:0] rd_addr_in,
    input  logic       mie_in,
    input  logic       meie_in,
    input  logic       mtie_in,
    input  logic       msie_in,
    input  logic       meip_in,
    input  logic       mtip_in,
    input  logic       msip_in,
    output logic [1:0] pc_src_out,
    output logic       flush_out,
    output logic       trap_taken_out,
    output logic       set_epc_out,
    output logic       set_cause_out,
    output logic [3:0] cause_out,
    output logic       i_or_e_out,
    output logic       mie_clear_out,
    output logic       mie_set_out,
    output logic       instret_inc_out,
    output logic       misaligned_exception_out
);

    localparam logic [3:0] HOLD_LAST = 4'(BOOT_HOLD_CYCLES - 1);

    mc_state_e  state_q;
    logic [3:0] hold_cnt_q;
    logic [3:0] cause_q;
    logic       i_or_e_q;
    logic [1:0] pc_src_q;
    logic       flush_q;
    logic       trap_entry_q;
    logic       mie_set_q;

    logic       trap;
    logic       mret;
    logic [3:0] cause_d;
    logic       i_or_e_d;
    logic       operating;

    msrv32_trap_prioritizer u_prio (
        .illegal_instr_i    (illegal_instr_in),
        .misaligned_load_i  (misaligned_load_in),
        .misaligned_store_i (misaligned_store_in),
        .misaligned_instr_i (misaligned_instr_in),
        .opcode_6_to_2_i    (opcode_6_to_2_in),
        .funct3_i           (funct3_in),
        .funct7_i           (funct7_in),
        .rs1_addr_i         (rs1_addr_in),
        .rs2_addr_i         (rs2_addr_in),
        .rd_addr_i          (rd_addr_in),
        .mie_i              (mie_in),
        .meie_i             (meie_in),
        .mtie_i             (mtie_in),
        .msie_i             (msie_in),
        .meip_i             (meip_in),
        .mtip_i             (mtip_in),
        .msip_i             (msip_in),
        .trap_o             (trap),
        .mret_o             (mret),
        .cause_o            (cause_d),
        .i_or_e_o           (i_or_e_d)
    );

    assign operating = (state_q == ST_OPERATING);

    // State sequencing with outputs registered alongside the state they belong to;
    // defaults describe OPERATING and each branch overrides what differs.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q      <= ST_RESET;
            hold_cnt_q   <= '0;
            cause_q      <= '0;
            i_or_e_q     <= 1'b0;
            pc_src_q     <= PC_BOOT;
            flush_q      <= 1'b1;
            trap_entry_q <= 1'b0;
            mie_set_q    <= 1'b0;
        end else begin
            state_q      <= ST_OPERATING;
            pc_src_q     <= PC_NEXT;
            flush_q      <= 1'b0;
            trap_entry_q <= 1'b0;
            mie_set_q    <= 1'b0;
            unique case (state_q)
                ST_RESET: begin
                    if (hold_cnt_q != HOLD_LAST) begin
                        hold_cnt_q <= hold_cnt_q + 4'd1;
                        state_q    <= ST_RESET;
                        pc_src_q   <= PC_BOOT;
                        flush_q    <= 1'b1;
                    end
                end
                ST_OPERATING: begin
                    if (trap) begin
                        state_q      <= ST_TRAP_TAKEN;
                        cause_q      <= cause_d;
                        i_or_e_q     <= i_or_e_d;
                        pc_src_q     <= PC_TRAP;
                        flush_q      <= 1'b1;
                        trap_entry_q <= 1'b1;
                    end else if (mret) begin
                        state_q   <= ST_TRAP_RETURN;
                        pc_src_q  <= PC_EPC;
                        flush_q   <= 1'b1;
                        mie_set_q <= 1'b1;
                    end
                end
                ST_TRAP_TAKEN, ST_TRAP_RETURN: ;
                default: ;
            endcase
        end
    end

    assign pc_src_out               = pc_src_q;
    assign flush_out                = flush_q;
    assign trap_taken_out           = trap_entry_q;
    assign set_epc_out              = trap_entry_q;
    assign set_cause_out            = trap_entry_q;
    assign mie_clear_out            = trap_entry_q;
    assign mie_set_out              = mie_set_q;
    assign cause_out                = cause_q;
    assign i_or_e_out               = i_or_e_q;
    assign instret_inc_out          = operating && !trap;
    assign misaligned_exception_out = operating &&
        (misaligned_load_in || misaligned_store_in || misaligned_instr_in);

endmodule

// File: tb/tb_msrv32_machine_control.sv
// Scoreboard bench for msrv32_machine_control: a cycle-level behavioural model
// predicts outputs, monitors compare them as the DUT presents them.
module tb_msrv32_machine_control;

    localparam int unsigned BOOT = 1;

    logic       clk = 1'b0;
    logic       rst_in;
    logic       illegal, mis_load, mis_store, mis_instr;
    logic [4:0] opc, rs1, rs2, rd;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       mie, meie, mtie, msie, meip, mtip, msip;

    logic [1:0] pc_src;
    logic       flush, trap_taken, set_epc, set_cause, i_or_e, mie_clear, mie_set;
    logic [3:0] cause;
    logic       instret_inc, mis_exc;

    msrv32_machine_control #(.BOOT_HOLD_CYCLES(BOOT)) dut (
        .clk_in                   (clk),
        .rst_in                   (rst_in),
        .illegal_instr_in         (illegal),
        .misaligned_load_in       (mis_load),
        .misaligned_store_in      (mis_store),
        .misaligned_instr_in      (mis_instr),
        .opcode_6_to_2_in         (opc),
        .funct3_in                (f3),
        .funct7_in                (f7),
        .rs1_addr_in              (rs1),
        .rs2_addr_in              (rs2),
        .rd_addr_in               (rd),
        .mie_in                   (mie),
        .meie_in                  (meie),
        .mtie_in                  (mtie),
        .msie_in                  (msie),
        .meip_in                  (meip),
        .mtip_in                  (mtip),
        .msip_in                  (msip),
        .pc_src_out               (pc_src),
        .flush_out                (flush),
        .trap_taken_out           (trap_taken),
        .set_epc_out              (set_epc),
        .set_cause_out            (set_cause),
        .cause_out                (cause),
        .i_or_e_out               (i_or_e),
        .mie_clear_out            (mie_clear),
        .mie_set_out              (mie_set),
        .instret_inc_out          (instret_inc),
        .misaligned_exception_out (mis_exc)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [13:0] exp_reg_q[$];
    logic [1:0]  exp_comb_q[$];

    // Reference model: boot cycles left, pending redirect (0 none, 1 trap vector, 2 mepc)
    bit model_valid = 1'b0;
    int boot_left   = 0;
    int redirect    = 0;
    int m_cause     = 0;
    bit m_ie        = 1'b0;

    function automatic bit is_priv();
        return opc == 5'b11100 && f3 == 3'd0 && rs1 == 5'd0 && rd == 5'd0;
    endfunction

    // Scan the priority list from lowest to highest so the highest hit wins
    function automatic void find_trap(output bit hit, output int c, output bit ie);
        bit conds[9];
        int codes[9];
        conds[0] = mis_instr;                               codes[0] = 0;
        conds[1] = illegal;                                 codes[1] = 2;
        conds[2] = is_priv() && f7 == 7'd0 && rs2 == 5'd1;  codes[2] = 3;
        conds[3] = mis_load;                                codes[3] = 4;
        conds[4] = mis_store;                               codes[4] = 6;
        conds[5] = is_priv() && f7 == 7'd0 && rs2 == 5'd0;  codes[5] = 11;
        conds[6] = mie && meie && meip;                     codes[6] = 11;
        conds[7] = mie && msie && msip;                     codes[7] = 3;
        conds[8] = mie && mtie && mtip;                     codes[8] = 7;
        hit = 1'b0; c = 0; ie = 1'b0;
        for (int k = 8; k >= 0; k--) begin
            if (conds[k]) begin
                hit = 1'b1;
                c   = codes[k];
                ie  = (k >= 6);
            end
        end
    endfunction

    function automatic logic [13:0] expected_regs();
        logic [1:0] pc;
        bit fl, ent, ms;
        pc = 2'd3; fl = 1'b0; ent = 1'b0; ms = 1'b0;
        if (boot_left > 0) begin
            pc = 2'd0; fl = 1'b1;
        end else if (redirect == 1) begin
            pc = 2'd2; fl = 1'b1; ent = 1'b1;
        end else if (redirect == 2) begin
            pc = 2'd1; fl = 1'b1; ms = 1'b1;
        end
        return {pc, fl, ent, ent, ent, 4'(m_cause), m_ie, ent, ms};
    endfunction

    // Evaluate one cycle with the current inputs, queue expectations, advance
    task automatic step();
        bit hit, ie, running, mret;
        int c;
        running = model_valid && boot_left == 0 && redirect == 0;
        find_trap(hit, c, ie);
        mret = is_priv() && f7 == 7'b0011000 && rs2 == 5'd2;
        if (model_valid)
            exp_comb_q.push_back({running && !hit, running && (mis_load || mis_store || mis_instr)});
        if (rst_in) begin
            model_valid = 1'b1;
            boot_left   = BOOT;
            redirect    = 0;
            m_cause     = 0;
            m_ie        = 1'b0;
        end else if (model_valid) begin
            if (boot_left > 0)       boot_left--;
            else if (redirect != 0)  redirect = 0;
            else if (hit) begin
                redirect = 1; m_cause = c; m_ie = ie;
            end else if (mret)       redirect = 2;
        end
        if (model_valid) exp_reg_q.push_back(expected_regs());
        @(negedge clk);
    endtask

    task automatic set_idle();
        rst_in = 1'b0; illegal = 1'b0; mis_load = 1'b0; mis_store = 1'b0; mis_instr = 1'b0;
        opc = 5'b01100; f3 = 3'd0; f7 = 7'd0; rs1 = 5'd1; rs2 = 5'd2; rd = 5'd3;
        mie = 1'b0; meie = 1'b0; mtie = 1'b0; msie = 1'b0; meip = 1'b0; mtip = 1'b0; msip = 1'b0;
    endtask

    task automatic set_sys(input logic [6:0] f7v, input logic [4:0] rs2v);
        opc = 5'b11100; f3 = 3'd0; rs1 = 5'd0; rd = 5'd0; f7 = f7v; rs2 = rs2v;
    endtask

    task automatic rand_inputs();
        int kind;
        kind = $urandom_range(0, 9);
        opc = 5'($urandom); f3 = 3'($urandom); f7 = 7'($urandom);
        rs1 = 5'($urandom); rs2 = 5'($urandom); rd = 5'($urandom);
        if (kind == 0) set_sys(7'd0, 5'd0);
        if (kind == 1) set_sys(7'd0, 5'd1);
        if (kind == 2) set_sys(7'b0011000, 5'd2);
        if (kind == 3) begin
            set_sys(7'b0011000, 5'd2);
            rd = 5'($urandom_range(1, 31));
        end
        illegal   = ($urandom_range(0, 11) == 0);
        mis_load  = ($urandom_range(0, 15) == 0);
        mis_store = ($urandom_range(0, 15) == 0);
        mis_instr = ($urandom_range(0, 15) == 0);
        mie  = 1'($urandom); meie = 1'($urandom); mtie = 1'($urandom); msie = 1'($urandom);
        meip = ($urandom_range(0, 3) == 0);
        mtip = ($urandom_range(0, 3) == 0);
        msip = ($urandom_range(0, 3) == 0);
        rst_in = ($urandom_range(0, 39) == 0);
    endtask

    // Registered outputs, checked just after the active edge
    initial forever begin
        logic [13:0] e, got;
        @(posedge clk);
        #1;
        if (exp_reg_q.size() > 0) begin
            e   = exp_reg_q.pop_front();
            got = {pc_src, flush, trap_taken, set_epc, set_cause, cause, i_or_e, mie_clear, mie_set};
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL regs t=%0t got pc/fl/tt/epc/cs/cause/ie/clr/set=%b required=%b",
                         $time, got, e);
            end
        end
    end

    // Combinational outputs, checked mid-cycle once inputs have settled
    initial forever begin
        logic [1:0] e, got;
        @(negedge clk);
        #2;
        if (exp_comb_q.size() > 0) begin
            e   = exp_comb_q.pop_front();
            got = {instret_inc, mis_exc};
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL comb t=%0t got instret/misaligned=%b required=%b", $time, got, e);
            end
        end
    end

    initial begin
        set_idle();
        rst_in = 1'b1;
        @(negedge clk);
        repeat (3) step();
        rst_in = 1'b0;
        repeat (3) step();

        illegal = 1'b1; step();
        illegal = 1'b0; step(); step();

        set_sys(7'd0, 5'd0); meip = 1'b1; meie = 1'b1; mie = 1'b1; step();
        set_idle(); step();
        mtip = 1'b1; mtie = 1'b1; mie = 1'b1; step();
        set_idle(); step(); step();

        msip = 1'b1; msie = 1'b1; mie = 1'b0; step(); step();
        mie = 1'b1; step();
        set_idle(); step(); step();

        set_sys(7'b0011000, 5'd2); step();
        set_idle(); step();
        set_sys(7'b0011000, 5'd2); mis_load = 1'b1; step();
        set_idle(); step(); step();

        illegal = 1'b1; step();
        set_idle(); rst_in = 1'b1; step();
        rst_in = 1'b0; step(); step(); step();

        repeat (800) begin
            rand_inputs();
            step();
        end

        set_idle();
        repeat (3) step();
        @(posedge clk);
        #3;
        checks++;
        if (exp_reg_q.size() != 0 || exp_comb_q.size() != 0) begin
            failures++;
            $display("FAIL drain got pending=%0d required=0", exp_reg_q.size() + exp_comb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
